// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// instruction classes and the ALUop / wb_sel / trap_cause codes.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    ST_BOOT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  // CL_NONE doubles as the "illegal opcode" result of decode_opcode
  typedef enum logic [2:0] {
    CL_NONE, CL_R, CL_I, CL_LOAD, CL_STORE, CL_BR, CL_JAL, CL_JALR
  } op_class_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_JUMP   = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic op_class_t decode_opcode(input logic [6:0] opc);
    case (opc)
      OPC_R:     return CL_R;
      OPC_I:     return CL_I;
      OPC_LOAD:  return CL_LOAD;
      OPC_STORE: return CL_STORE;
      OPC_BR:    return CL_BR;
      OPC_JAL:   return CL_JAL;
      OPC_JALR:  return CL_JALR;
      default:   return CL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_timeout_timer.sv
// Counts consecutive un-acknowledged memory request cycles; expire flags the
// last allowed cycle so the FSM can trap on the following edge.
module multicycle_ctrl_mem_timeout_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear || !count_en) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

  // a ready on this cycle deasserts count_en, so ready beats timeout
  assign expire = count_en && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a shared-memory req/ready
// handshake, retired-instruction counter and sticky trap on illegal op / timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 pc_src,
  output logic [1:0]           ALUop,
  output logic                 ALUsrc,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  state_t    state, next_state;
  op_class_t op_class;
  logic      retire;
  logic      cause_set;
  logic [1:0] cause_new;
  logic      timer_en, timer_clear, expire;

  // branch_taken is combined with pc_write_cond inside the datapath
  logic unused_branch_taken;
  assign unused_branch_taken = branch_taken;

  multicycle_ctrl_mem_timeout_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (timer_en),
    .clear    (timer_clear),
    .expire   (expire)
  );

  assign timer_en    = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
  assign timer_clear = (next_state != state);
  assign trap        = (state == ST_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      op_class   <= CL_NONE;
      instret    <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) op_class <= decode_opcode(opcode);
      if (retire) instret <= instret + INSTRET_W'(1);
      if (cause_set) trap_cause <= cause_new;
    end
  end

  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    ALUop         = ALU_ADD;
    ALUsrc        = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALU;
    retire        = 1'b0;
    cause_set     = 1'b0;
    cause_new     = CAUSE_NONE;
    case (state)
      ST_BOOT: next_state = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = ST_DECODE;
        end else if (expire) begin
          next_state = ST_TRAP;
          cause_set  = 1'b1;
          cause_new  = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (decode_opcode(opcode) == CL_NONE) begin
          next_state = ST_TRAP;
          cause_set  = 1'b1;
          cause_new  = CAUSE_ILLEGAL;
        end else begin
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALUsrc = !(op_class inside {CL_R, CL_BR, CL_JAL});
        case (op_class)
          CL_R, CL_I: begin
            ALUop      = ALU_FUNCT;
            next_state = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            ALUop      = ALU_ADD;
            next_state = ST_MEM;
          end
          CL_BR: begin
            ALUop         = ALU_BRANCH;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
            retire        = 1'b1;
            next_state    = ST_FETCH;
          end
          CL_JAL, CL_JALR: begin
            ALUop      = ALU_JUMP;
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            reg_write  = 1'b1;
            wb_sel     = WB_PC4;
            retire     = 1'b1;
            next_state = ST_FETCH;
          end
          default: next_state = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op_class == CL_STORE);
        if (mem_ready) begin
          if (op_class == CL_STORE) begin
            retire     = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end else if (expire) begin
          next_state = ST_TRAP;
          cause_set  = 1'b1;
          cause_new  = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        wb_sel     = (op_class == CL_LOAD) ? WB_MEM : WB_ALU;
        retire     = 1'b1;
        next_state = ST_FETCH;
      end
      ST_TRAP: next_state = ST_TRAP;
      default: next_state = ST_BOOT;
    endcase
  end

endmodule
